// File: rtl/t3_compare.sv
// t3_compare: registered balanced-ternary magnitude comparator, O_out = sign(I_a - I_b)
module t3_compare #(
    parameter int TRITS = 16
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic [2*TRITS-1:0] I_a,
    input  logic [2*TRITS-1:0] I_b,
    output logic [1:0]         O_out,
    output logic               O_invalid
);
    logic [1:0] out_d, out_q;
    logic       inv_d, inv_q;

    // Ordinal of a trit code (-1 -> 0, 0 -> 1, +1 -> 2); the illegal code folds onto 0
    function automatic logic [1:0] ord(input logic [1:0] c);
        return c == 2'b10 ? 2'd2 : c == 2'b01 ? 2'd0 : 2'd1;
    endfunction

    // Scan LSB to MSB so that the most significant differing trit is the last to write the result
    always_comb begin
        out_d = 2'b00;
        inv_d = 1'b0;
        for (int i = 0; i < TRITS; i++) begin
            inv_d = inv_d | (&I_a[2*i +: 2]) | (&I_b[2*i +: 2]);
            out_d = ord(I_a[2*i +: 2]) > ord(I_b[2*i +: 2]) ? 2'b10 :
                    ord(I_a[2*i +: 2]) < ord(I_b[2*i +: 2]) ? 2'b01 : out_d;
        end
    end

    // Output registers, cleared asynchronously by reset
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            out_q <= 2'b00;
            inv_q <= 1'b0;
        end else begin
            out_q <= out_d;
            inv_q <= inv_d;
        end
    end

    assign O_out     = out_q;
    assign O_invalid = inv_q;
endmodule

// File: tb/tb_t3_compare.sv
// tb_t3_compare: vector table, random model scoreboard and reset corner cases for t3_compare
module tb_t3_compare;
    localparam int TRITS = 16;
    localparam int W = 2*TRITS;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   o;
        logic         inv;
    } vec_t;

    typedef struct {
        logic [1:0] o;
        logic       inv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   out;
    logic         inv;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[14];

    t3_compare #(.TRITS(TRITS)) dut (
        .I_clk(clk),
        .I_rst_n(rst_n),
        .I_a(a),
        .I_b(b),
        .O_out(out),
        .O_invalid(inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Independent model: evaluate both operands as integers
    function automatic longint tval(input logic [W-1:0] x);
        longint s = 0;
        longint p = 1;
        for (int i = 0; i < TRITS; i++) begin
            logic [1:0] c = x[2*i +: 2];
            s += c == 2'b10 ? p : c == 2'b01 ? -p : 0;
            p *= 3;
        end
        return s;
    endfunction

    function automatic logic has_ill(input logic [W-1:0] x);
        for (int i = 0; i < TRITS; i++)
            if (x[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one vector between edges, push its expectation, pop and compare after the edge
    task automatic step(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [1:0] eo, input logic ei);
        exp_t e;
        @(negedge clk);
        a = va;
        b = vb;
        sb.push_back('{eo, ei});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, ".out"}, out, e.o);
            check({name, ".inv"}, {1'b0, inv}, {1'b0, e.inv});
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        longint va, vb;
        tbl[0]  = '{32'h4,        32'h4,        2'b00, 1'b0};
        tbl[1]  = '{32'h0,        32'h0,        2'b00, 1'b0};
        tbl[2]  = '{32'h0,        32'h2,        2'b01, 1'b0};
        tbl[3]  = '{32'h0,        32'h1,        2'b10, 1'b0};
        tbl[4]  = '{32'h1,        32'h4,        2'b10, 1'b0};
        tbl[5]  = '{32'hA,        32'h5,        2'b10, 1'b0};
        tbl[6]  = '{32'hAAA,      32'h2AA,      2'b10, 1'b0};
        tbl[7]  = '{32'h6AA,      32'h2AA,      2'b01, 1'b0};
        tbl[8]  = '{32'h2AA,      32'hAAA,      2'b01, 1'b0};
        tbl[9]  = '{32'h80000000, 32'h2AAAAAAA, 2'b10, 1'b0};
        tbl[10] = '{32'h3,        32'h0,        2'b00, 1'b1};
        tbl[11] = '{32'h0,        32'h0,        2'b00, 1'b0};
        tbl[12] = '{32'h0,        32'hC,        2'b00, 1'b1};
        tbl[13] = '{32'h8,        32'h3,        2'b10, 1'b1};

        #12;
        check("reset.out", out, 2'b00);
        check("reset.inv", {1'b0, inv}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            step($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].inv);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            if (i % 3 != 0) begin
                for (int k = 0; k < TRITS; k++) begin
                    if (ra[2*k +: 2] == 2'b11) ra[2*k +: 2] = 2'b10;
                    if (rb[2*k +: 2] == 2'b11) rb[2*k +: 2] = 2'b01;
                end
            end
            va = tval(ra);
            vb = tval(rb);
            step($sformatf("rnd%0d", i), ra, rb,
                 va > vb ? 2'b10 : va < vb ? 2'b01 : 2'b00, has_ill(ra) | has_ill(rb));
        end

        step("pre_rst", 32'hB, 32'h0, 2'b10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out", out, 2'b00);
        check("async_rst.inv", {1'b0, inv}, 2'b00);
        @(posedge clk);
        #1;
        check("held_rst.out", out, 2'b00);
        @(negedge clk);
        a = 32'h2;
        b = 32'h0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.out", out, 2'b10);
        check("post_rst.inv", {1'b0, inv}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/t3_compare.md
Name: t3_compare

Overview:
- Balanced-ternary magnitude comparator for packed 2-bit-per-trit words.
- Compares operands I_a and I_b and returns sign(I_a − I_b), encoded as a single trit.
- Used by ternary ALU and branch logic.
- Output is registered: one clock, asynchronous active-low reset.

Parameters:
- TRITS, 16, number of trits per operand; each operand is 2*TRITS bits wide.

Ports:
- I_clk  input  1  rising-edge clock.
- I_rst_n  input  1  asynchronous active-low reset.
- I_a  input  2*TRITS  operand A; trit i occupies bits [2i+1:2i], trit 0 is least significant.
- I_b  input  2*TRITS  operand B; same packing as I_a.
- O_out  output  2  registered comparison result trit.
- O_invalid  output  1  registered flag: an illegal trit code was present in I_a or I_b.

Behaviour:
- Interface: one clock (I_clk); reset I_rst_n is asynchronous and active-low.
- Trit encoding, per 2-bit field:
  - 00 = 0
  - 01 = −1
  - 10 = +1
  - 11 = illegal
- Result encoding on O_out:
  - 00: I_a == I_b
  - 01: I_a < I_b (sign −1)
  - 10: I_a > I_b (sign +1)
  - 11: never driven.
- Comparison rule:
  - Scan trits from most significant (TRITS−1) down to 0.
  - The first position where the trits differ decides the result.
  - At that position, a greater trit value in A gives 10; a lesser trit value in A gives 01.
  - This rule is exact for balanced ternary, because lower trits can never outweigh one higher trit.
  - If no position differs, the result is 00.
- Illegal code 11:
  - Treated as value 0 for the comparison.
  - Sets O_invalid for that sample.
- Timing:
  - I_a and I_b are sampled on every rising edge of I_clk.
  - O_out and O_invalid reflect those inputs from that edge onward: 1-cycle latency, fully pipelined, a new comparison every cycle.
- Reset:
  - While I_rst_n = 0, O_out = 00 and O_invalid = 0, asynchronously.
  - The first valid result appears on the first rising edge after reset is released.
  - Asserting reset mid-operation clears the outputs immediately, regardless of the clock.
- The comparison logic between the input pins and the output registers is purely combinational.
  - No X propagation.
  - Result depends only on the current-cycle inputs.
- Widths: no arithmetic carry and no overflow are possible; the result is always one of 00, 01, 10.

Test Plan:
- Equal operands: a=0x4, b=0x4 → O_out=00 one cycle later. Also a=b=0 → 00.
- Single low trit against zero:
  - a=0x0, b=0x2 (b=+1) → 01.
  - a=0x0, b=0x1 (b=−1) → 10.
- Position weighting: a=0x01 (−1), b=0x04 (−3) → 10.
  - Also a=0xA (+4), b=0x5 (−4) → 10.
- Most significant trit dominates:
  - a=0xAAA, b=0x2AA → 10.
  - a=0x6AA (top trit −1), b=0x2AA → 01.
  - Full width: a=0x80000000, b=0x2AAAAAAA → 10.
- Illegal code: a=0x3, b=0x0 → O_out=00, O_invalid=1.
  - Next cycle with legal inputs → O_invalid returns to 0.
- Reset:
  - Drive unequal inputs and wait for O_out=10.
  - Assert I_rst_n=0 between clock edges → O_out=00 and O_invalid=0 immediately.
  - Release reset → correct result on the next rising edge.
